// File: rtl/wb_uart_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_master_pkg
// Purpose  : Shared definitions for the Wishbone UART register initiator:
//            UART register addresses, wb_we polarity, FSM state encoding.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package wb_uart_master_pkg;

  // UART slave register map
  localparam logic [1:0] UART_ADDR_TX       = 2'b00;
  localparam logic [1:0] UART_ADDR_RX       = 2'b01;
  localparam logic [1:0] UART_ADDR_FREQ_DIV = 2'b10;

  // The UART slave uses an inverted write-enable: low writes, high reads
  localparam logic WB_WE_WRITE = 1'b0;
  localparam logic WB_WE_READ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/wb_uart_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_master
// Purpose  : Wishbone initiator for the UART register port. Converts a
//            valid/ready request stream into single stb/ack transactions and
//            returns one response per request, with ack and ack-release
//            timeouts reported as rsp_err.
// Ports    : wb_clk, reset         clock, synchronous active-high reset
//            req_valid/ready/write/addr/wdata   request stream
//            rsp_valid/ready/rdata/err          response stream
//            busy                  high whenever not idle
//            wb_addr/data_out/data_in/we/stb/ack  Wishbone to UART slave
// Revision : 1.0  initial release
// ============================================================================
module wb_uart_master
  import wb_uart_master_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int REL_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       wb_clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic [1:0] wb_addr,
  output logic [7:0] wb_data_out,
  input  logic [7:0] wb_data_in,
  output logic       wb_we,
  output logic       wb_stb,
  input  logic       wb_ack
);

  // Last counter value before the timeout fires (counter starts at 0)
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;
  logic [1:0]       wb_addr_q, wb_addr_d;
  logic [7:0]       wb_data_out_q, wb_data_out_d;
  logic             wb_we_q, wb_we_d;
  logic             wb_stb_q, wb_stb_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    wb_addr_d     = wb_addr_q;
    wb_data_out_d = wb_data_out_q;
    wb_we_d       = wb_we_q;
    wb_stb_d      = wb_stb_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wb_addr_d     = req_addr;
          wb_data_out_d = req_wdata;
          wb_we_d       = req_write ? WB_WE_WRITE : WB_WE_READ;
          wb_stb_d      = 1'b1;
          cnt_d         = '0;
          req_ready_d   = 1'b0;
          state_d       = ST_STROBE;
        end
      end
      ST_STROBE: begin
        // Ack is tested first so an ack on the timeout cycle still succeeds
        if (wb_ack) begin
          wb_stb_d    = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = (wb_we_q == WB_WE_READ) ? wb_data_in : 8'h00;
          cnt_d       = '0;
          state_d     = ST_RELEASE;
        end else if (cnt_q == ACK_LAST) begin
          wb_stb_d    = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
          cnt_d       = '0;
          state_d     = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        // Wait for the slave to drop ack so the next strobe is not mis-acked
        if (!wb_ack) begin
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_RESP;
        end else if (cnt_q == REL_LAST) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge wb_clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      wb_addr_q     <= 2'b00;
      wb_data_out_q <= 8'h00;
      wb_we_q       <= WB_WE_READ;
      wb_stb_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_out_q <= wb_data_out_d;
      wb_we_q       <= wb_we_d;
      wb_stb_q      <= wb_stb_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data_out = wb_data_out_q;
  assign wb_we       = wb_we_q;
  assign wb_stb      = wb_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_uart_master
// Purpose  : Self-checking bench for wb_uart_master with a small UART
//            register slave (normal, never-ack and stuck-ack behaviours) and
//            a transaction-level timing model of the expected outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_uart_master;

  localparam int ACK_TO = 16;
  localparam int REL_TO = 16;

  // Slave behaviours
  localparam int M_NORMAL = 0;
  localparam int M_NOACK  = 1;
  localparam int M_STUCK  = 2;

  logic       wb_clk = 1'b0;
  logic       reset  = 1'b1;
  logic       req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [1:0] req_addr  = 2'b00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready, rsp_valid, rsp_err, busy, wb_we, wb_stb;
  logic [7:0] rsp_rdata, wb_data_out, wb_data_in;
  logic [1:0] wb_addr;
  logic       wb_ack;

  wb_uart_master #(.ACK_TIMEOUT(ACK_TO), .REL_TIMEOUT(REL_TO), .CNT_W(8)) dut (
    .wb_clk(wb_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .wb_addr(wb_addr), .wb_data_out(wb_data_out), .wb_data_in(wb_data_in),
    .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack)
  );

  always #5 wb_clk = ~wb_clk;

  // ---------------- UART register slave ----------------
  int         slv_mode = M_NORMAL;
  logic       slv_ack  = 1'b0;
  logic [7:0] slv_regs [4] = '{8'h00, 8'h5A, 8'h00, 8'h00};

  always @(posedge wb_clk) begin
    case (slv_mode)
      M_NORMAL: slv_ack <= wb_stb;
      M_NOACK:  slv_ack <= 1'b0;
      default:  slv_ack <= slv_ack | wb_stb;
    endcase
    if (wb_stb && slv_ack && !wb_we) slv_regs[wb_addr] <= wb_data_out;
  end
  assign wb_ack     = slv_ack;
  assign wb_data_in = slv_regs[wb_addr];

  // ---------------- bookkeeping ----------------
  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  bit last_rst = 1'b0;

  always @(posedge wb_clk) begin
    cyc      <= cyc + 1;
    last_rst <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- transaction model ----------------
  // With a slave that answers one edge after seeing stb, the timing of each
  // transaction follows directly from the handshake rules: stb is high for
  // two cycles (or ACK_TO on a missing ack) and the response appears 4 cycles
  // after accept, ACK_TO+1 on ack timeout, 2+REL_TO on a stuck ack.
  bit         in_txn = 1'b0;
  int         t_acc, m_lat, m_stb_len;
  bit         m_write, m_err;
  logic [1:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  logic [7:0] mdl_regs [4] = '{8'h00, 8'h5A, 8'h00, 8'h00};

  function automatic int lat_of(input int mode);
    if (mode == M_NOACK) return ACK_TO + 1;
    if (mode == M_STUCK) return 2 + REL_TO;
    return 4;
  endfunction

  function automatic int stb_len_of(input int mode);
    return (mode == M_NOACK) ? ACK_TO : 2;
  endfunction

  // Compare process: every cycle, away from the active edge
  always @(negedge wb_clk) begin
    int d;
    if (last_rst) begin
      chk("rst_stb", wb_stb, 1'b0);
      chk("rst_we", wb_we, 1'b1);
      chk("rst_addr", wb_addr, 2'b00);
      chk("rst_dout", wb_data_out, 8'h00);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_rdata", rsp_rdata, 8'h00);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end else if (!in_txn) begin
      chk("idle_stb", wb_stb, 1'b0);
      chk("idle_rsp_valid", rsp_valid, 1'b0);
      chk("idle_req_ready", req_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end else begin
      d = cyc - t_acc;
      chk("txn_stb", wb_stb, (d < m_stb_len) ? 1'b1 : 1'b0);
      chk("txn_we", wb_we, m_write ? 1'b0 : 1'b1);
      chk("txn_addr", wb_addr, m_addr);
      chk("txn_dout", wb_data_out, m_wdata);
      chk("txn_busy", busy, 1'b1);
      chk("txn_req_ready", req_ready, 1'b0);
      chk("txn_rsp_valid", rsp_valid, (d >= m_lat) ? 1'b1 : 1'b0);
      if (d >= m_lat) begin
        chk("txn_rdata", rsp_rdata, m_rdata);
        chk("txn_err", rsp_err, m_err);
      end
    end
  end

  // Issue one request, wait for its response, optionally stall rsp_ready
  // (with a competing request held on the input), then consume it.
  task automatic do_txn(input bit wr, input logic [1:0] a, input logic [7:0] wd,
                        input int mode, input int hold,
                        input int lat_lit, input logic [7:0] rd_lit, input bit err_lit);
    bit got;
    @(posedge wb_clk); #1;
    slv_mode  = mode;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    m_write   = wr; m_addr = a; m_wdata = wd;
    m_lat     = lat_of(mode);
    m_stb_len = stb_len_of(mode);
    m_err     = (mode != M_NORMAL);
    m_rdata   = (!wr && mode == M_NORMAL) ? mdl_regs[a] : 8'h00;
    chk("req_ready_before_accept", req_ready, 1'b1);
    @(posedge wb_clk); #1;
    t_acc = cyc; in_txn = 1'b1; req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge wb_clk); #1;
    end
    if (!got) begin
      n_chk++;
      $display("FAIL rsp_timeout: rsp_valid=%0b expected 1 within 40 cycles", rsp_valid);
    end else begin
      chk("latency", cyc - t_acc, lat_lit);
      chk("rdata_lit", rsp_rdata, rd_lit);
      chk("err_lit", rsp_err, err_lit);
    end
    slv_mode = M_NORMAL;
    if (hold > 0) begin
      req_valid = 1'b1; req_write = ~wr; req_addr = a ^ 2'b11; req_wdata = ~wd;
      repeat (hold) begin
        @(posedge wb_clk); #1;
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge wb_clk); #1;
    rsp_ready = 1'b0;
    in_txn    = 1'b0;
    if (wr && mode != M_NOACK) mdl_regs[a] = wd;
  endtask

  initial begin
    repeat (3) @(posedge wb_clk);
    #1;
    chk("reset_stb_lit", wb_stb, 1'b0);
    chk("reset_we_lit", wb_we, 1'b1);
    chk("reset_req_ready_lit", req_ready, 1'b1);
    reset = 1'b0;
    // rsp_ready while nothing is pending must be ignored
    rsp_ready = 1'b1;
    @(posedge wb_clk); #1;
    rsp_ready = 1'b0;

    do_txn(1'b1, 2'd0, 8'h41, M_NORMAL, 0, 4, 8'h00, 1'b0);
    chk("slave_tx_byte", slv_regs[0], 8'h41);
    do_txn(1'b0, 2'd1, 8'h00, M_NORMAL, 0, 4, 8'h5A, 1'b0);
    do_txn(1'b1, 2'd2, 8'h9C, M_NORMAL, 10, 4, 8'h00, 1'b0);
    chk("slave_freq_div", slv_regs[2], 8'h9C);
    do_txn(1'b0, 2'd2, 8'h00, M_NORMAL, 0, 4, 8'h9C, 1'b0);
    do_txn(1'b0, 2'd1, 8'h00, M_NOACK, 0, 17, 8'h00, 1'b1);
    do_txn(1'b0, 2'd1, 8'h00, M_STUCK, 3, 18, 8'h00, 1'b1);
    do_txn(1'b1, 2'd3, 8'hE7, M_NORMAL, 0, 4, 8'h00, 1'b0);
    do_txn(1'b0, 2'd3, 8'h00, M_NORMAL, 0, 4, 8'hE7, 1'b0);

    // Reset while the strobe is up: the request is dropped without response
    @(posedge wb_clk); #1;
    slv_mode  = M_NOACK;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1; req_wdata = 8'h00;
    m_write = 1'b0; m_addr = 2'd1; m_wdata = 8'h00;
    m_lat = lat_of(M_NOACK); m_stb_len = stb_len_of(M_NOACK);
    m_err = 1'b1; m_rdata = 8'h00;
    @(posedge wb_clk); #1;
    t_acc = cyc; in_txn = 1'b1; req_valid = 1'b0;
    repeat (5) begin
      @(posedge wb_clk); #1;
    end
    chk("pre_reset_stb", wb_stb, 1'b1);
    reset = 1'b1;
    @(posedge wb_clk); #1;
    in_txn = 1'b0;
    chk("mid_reset_stb", wb_stb, 1'b0);
    chk("mid_reset_rsp_valid", rsp_valid, 1'b0);
    chk("mid_reset_req_ready", req_ready, 1'b1);
    reset = 1'b0;
    slv_mode = M_NORMAL;
    repeat (4) begin
      @(posedge wb_clk); #1;
    end
    do_txn(1'b1, 2'd0, 8'h33, M_NORMAL, 0, 4, 8'h00, 1'b0);
    chk("slave_tx_byte_after_reset", slv_regs[0], 8'h33);

    repeat (3) @(posedge wb_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
